// File: rtl/senha_transmissor_pkg.sv
// Shared definitions for the safe password link: digit encodings, FSM states
// and a small sizing helper.
package senha_pkg;

  localparam logic [1:0] DIG_NULO = 2'b00;
  localparam logic [1:0] DIG_A    = 2'b01;
  localparam logic [1:0] DIG_B    = 2'b10;
  localparam logic [1:0] DIG_C    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_RESP,
    ST_DONE
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/senha_transmissor_if.sv
// Request/response bundle between a keypad-side requester and the transmitter.
interface senha_if #(
  parameter int unsigned N_DIGITS = 5
);
  logic                    start;
  logic [2*N_DIGITS-1:0]   code;
  logic                    led_in;
  logic [1:0]              digito;
  logic                    busy;
  logic                    done;
  logic                    unlocked;
  logic                    code_err;

  modport master (
    output start, code, led_in,
    input  digito, busy, done, unlocked, code_err
  );

  modport slave (
    input  start, code, led_in,
    output digito, busy, done, unlocked, code_err
  );
endinterface

// File: rtl/senha_transmissor_shift_reg.sv
// Loadable code register; shifts left one digit per advance and exposes the
// digit currently at the top.
module senha_shift_reg #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] load_val,
  output logic [1:0]       top
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load)         data_d = load_val;
    else if (advance) data_d = data_q << 2;
  end

  // NOTE: no reset on the data path; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign top = data_q[WIDTH-1 -: 2];

endmodule

// File: rtl/senha_transmissor.sv
// Keypad-side transmitter: sends a latched N-digit code as held digits with
// nulo gaps, then waits a bounded window for the safe's led.
module senha_transmissor
  import senha_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 5,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned RESP_TIMEOUT = 4
) (
  input logic     clk,
  input logic     reset,
  senha_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, RESP_TIMEOUT) + 1);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digito_q, digito_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             unlocked_q, unlocked_d;
  logic             code_err_q, code_err_d;

  logic             code_ok;
  logic             sr_load, sr_advance;
  logic [1:0]       sr_top;

  senha_shift_reg #(.WIDTH(2 * N_DIGITS)) u_shift (
    .clk      (clk),
    .load     (sr_load),
    .advance  (sr_advance),
    .load_val (bus.code),
    .top      (sr_top)
  );

  always_comb begin
    code_ok = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bus.code[2*i +: 2] == DIG_NULO) code_ok = 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    unlocked_d = unlocked_q;
    code_err_d = 1'b0;
    sr_load    = 1'b0;
    sr_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (code_ok) begin
            state_d    = ST_SEND;
            idx_d      = '0;
            unlocked_d = 1'b0;
            sr_load    = 1'b1;
          end else begin
            code_err_d = 1'b1;
          end
        end
      end
      // Advance on the last hold cycle so the next digit is on top by re-entry.
      ST_SEND: begin
        if (cnt_q == H_LAST) begin
          state_d    = ST_GAP;
          sr_advance = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == G_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_WAIT_RESP;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (bus.led_in) begin
          state_d    = ST_DONE;
          unlocked_d = 1'b1;
        end else if (cnt_q == T_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Restarts on each state change and saturates instead of wrapping.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    if (sr_load)                 digito_d = bus.code[2*N_DIGITS-1 -: 2];
    else if (state_d == ST_SEND) digito_d = sr_top;
    else                         digito_d = DIG_NULO;

    busy_d = (state_d == ST_SEND) || (state_d == ST_GAP) || (state_d == ST_WAIT_RESP);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      digito_q   <= DIG_NULO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unlocked_q <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      digito_q   <= digito_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      unlocked_q <= unlocked_d;
      code_err_q <= code_err_d;
    end
  end

  assign bus.digito   = digito_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.unlocked = unlocked_q;
  assign bus.code_err = code_err_q;

endmodule

// File: tb/tb_senha_transmissor.sv
// Bench for senha_transmissor: directed scenarios plus random transactions
// checked against a cycle-timeline model of the transmit/response protocol.
module tb_senha_transmissor;
  import senha_pkg::*;

  localparam int N  = 5;
  localparam int H  = 1;
  localparam int G  = 1;
  localparam int T  = 4;
  localparam int P  = H + G;
  localparam int CW = 2 * N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  senha_if #(.N_DIGITS(N)) bus ();

  senha_transmissor #(
    .N_DIGITS(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .RESP_TIMEOUT(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_unlocked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string ctx, input logic [1:0] d, input logic b,
                               input logic dn, input logic u, input logic ce);
    check({ctx, ".digito"},   32'(bus.digito),   32'(d));
    check({ctx, ".busy"},     32'(bus.busy),     32'(b));
    check({ctx, ".done"},     32'(bus.done),     32'(dn));
    check({ctx, ".unlocked"}, 32'(bus.unlocked), 32'(u));
    check({ctx, ".code_err"}, 32'(bus.code_err), 32'(ce));
  endtask

  function automatic logic [1:0] digit_of(input logic [CW-1:0] c, input int i);
    logic [CW-1:0] s;
    s = c >> (2 * (N - 1 - i));
    return s[1:0];
  endfunction

  function automatic bit code_legal(input logic [CW-1:0] c);
    for (int i = 0; i < N; i++) if (digit_of(c, i) == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // One transaction: accept edge, then cycle-by-cycle comparison against the
  // timeline (digit i held in cycles 1+i*P .. i*P+H, response window after).
  task automatic run_txn(input logic [CW-1:0] c, input bit [31:0] led_pat,
                         input bit [31:0] start_pat, input int rst_cycle,
                         input bit hold_start);
    int w0, done_cyc, i, j;
    bit result;
    logic [1:0] exp_d;

    bus.code  = c;
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    bus.code = CW'($urandom);

    if (!code_legal(c)) begin
      check_outputs("reject", 2'b00, 1'b0, 1'b0, exp_unlocked, 1'b1);
      tick();
      check_outputs("reject_next", 2'b00, 1'b0, 1'b0, exp_unlocked, 1'b0);
      return;
    end

    exp_unlocked = 1'b0;
    w0       = N * P + 1;
    done_cyc = w0 + T;
    result   = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (led_pat[w0 + k]) begin
        done_cyc = w0 + k + 1;
        result   = 1'b1;
        break;
      end
    end

    for (int t = 1; t <= done_cyc; t++) begin
      i = (t - 1) / P;
      j = (t - 1) % P;
      exp_d = (t < w0 && j < H) ? digit_of(c, i) : 2'b00;
      if (t == done_cyc) exp_unlocked = result;
      check_outputs($sformatf("cyc%0d", t), exp_d, t < done_cyc, t == done_cyc,
                    exp_unlocked, 1'b0);
      if (t == rst_cycle) begin
        reset      = 1'b1;
        bus.led_in = 1'b0;
        bus.start  = 1'b0;
        tick();
        reset        = 1'b0;
        exp_unlocked = 1'b0;
        check_outputs("after_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      bus.led_in = led_pat[t];
      if (!hold_start) bus.start = start_pat[t];
      tick();
    end

    check_outputs("idle", 2'b00, 1'b0, 1'b0, exp_unlocked, 1'b0);
    bus.led_in = 1'b0;
    if (!hold_start) bus.start = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] c;
    bit   [31:0]   led_pat, start_pat;
    int            rst_cycle;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.code     = '0;
    bus.led_in   = 1'b0;
    exp_unlocked = 1'b0;
    tick();
    check_outputs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    run_txn(10'h39B, 32'h0, 32'h0, 0, 1'b0);                // timeout
    run_txn(10'h39B, 32'h1000, 32'h0, 0, 1'b0);             // led at cycle 12
    run_txn(10'h398, 32'h0, 32'h0, 0, 1'b0);                // illegal, unlocked held
    run_txn(10'h39B, 32'h0, 32'h0, 5, 1'b0);                // reset mid-stream
    run_txn(10'h39B, 32'h800, 32'h0, 0, 1'b0);              // restart from digit 0
    run_txn(10'h39B, 32'h1C, 32'h40, 0, 1'b0);              // spurious led/start
    run_txn(10'h2E5, 32'h800, 32'h0, 0, 1'b1);              // back-to-back, unlock
    run_txn(10'h39B, 32'h0, 32'h0, 0, 1'b1);                // second clears unlocked
    bus.start = 1'b0;
    tick();
    check_outputs("post_b2b", 2'b00, 1'b0, 1'b0, exp_unlocked, 1'b0);

    for (int n = 0; n < 40; n++) begin
      c = '0;
      for (int d = 0; d < N; d++) c = (c << 2) | CW'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) c = c & ~(CW'(3) << (2 * $urandom_range(0, N - 1)));
      led_pat = '0;
      for (int b = 0; b < 32; b++) led_pat[b] = ($urandom_range(0, 4) == 0);
      start_pat = $urandom;
      rst_cycle = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 14)) : 0;
      run_txn(c, led_pat, start_pat, rst_cycle, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/senha_transmissor.md
Name: senha_transmissor

Overview:
- Keypad-side driver for the safe (cofre) password interface: the transmitting end of the 2-bit digit stream the safe controller consumes.
- On a start request it latches an N-digit code and emits it as a timed digit stream: each digit is held, then followed by a nulo gap.
- It then watches the safe's led for a bounded window and reports unlocked/failed.
- Used as a bench/stimulus source and as the front end of the keypad emulator.

Parameters:
- N_DIGITS, 5, number of code digits transmitted.
- HOLD_CYCLES, 1, cycles each digit stays on digito (≥1).
- GAP_CYCLES, 1, cycles of nulo after each digit (≥1).
- RESP_TIMEOUT, 4, max cycles to wait for led_in after the last gap (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to transmit; sampled only in IDLE.
- code  in  2*N_DIGITS  digit sequence, MSB pair sent first (CBABC = 10'b11_10_01_10_11 = 10'h39B).
- led_in  in  1  safe's led output.
- digito  out  2  digit stream: nulo=00, A=01, B=10, C=11.
- busy  out  1  high while in SEND, GAP or WAIT_RESP.
- done  out  1  one-cycle pulse at end of transaction.
- unlocked  out  1  result of last transaction; held until next accepted start.
- code_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; digito=00, busy=0, done=0, unlocked=0, code_err=0 on the cycle after reset is sampled high. Reset mid-transaction aborts immediately, with no done pulse.
- All outputs are registered.
- States: IDLE, SEND, GAP, WAIT_RESP, DONE.
- IDLE, start=1, all code digits ≠00: latch code, clear unlocked, go to SEND. "Cycle 1" = first cycle after the accepting edge.
- IDLE, start=1, any code digit =00: stay in IDLE, pulse code_err for 1 cycle, leave unlocked unchanged.
- Digit i (i=0 first) drives digito in cycles 1+i*(H+G) .. i*(H+G)+H, then 00 for G cycles. H=HOLD_CYCLES, G=GAP_CYCLES.
- SEND→GAP after H cycles. GAP→SEND (next digit) after G cycles, or GAP→WAIT_RESP after the last digit's gap.
- WAIT_RESP: starts at cycle N*(H+G)+1; digito=00; led_in sampled every cycle.
  - First cycle led_in=1: next cycle is DONE with unlocked=1.
  - If RESP_TIMEOUT cycles pass with no led: DONE with unlocked=0.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE, including the DONE cycle. start held high re-triggers one cycle after DONE.
- led_in is ignored outside WAIT_RESP. led_in high during SEND/GAP does not set unlocked.
- Counters:
  - digit index: clog2(N_DIGITS) bits, saturates at N_DIGITS-1.
  - cycle counter: clog2(max(H,G,RESP_TIMEOUT)+1) bits, reset on every state change.
  - No wrap-around is permitted.

Decomposition:
- Package senha_pkg holds the digit encodings (DIG_NULO, DIG_A, DIG_B, DIG_C) and the state enum, both shared with the safe controller and benches.
- Single sub-module: senha_shift_reg, a loadable 2*N-bit register that shifts left by 2 on advance and outputs its top pair.
- The FSM plus counters stay in the top module.

Test Plan (N=5, H=1, G=1, RESP_TIMEOUT=4):
- Basic unlock: reset, then start with code=10'h39B and led_in rising at cycle 12 → digito 11,00,10,00,01,00,10,00,11,00 in cycles 1-10; done=1 and unlocked=1 at cycle 13; busy=1 in cycles 1-12.
- Timeout: code=10'h39B, led_in=0 throughout → WAIT_RESP cycles 11-14, done=1 and unlocked=0 at cycle 15.
- Illegal code: code=10'h398 (last digit 00) → code_err pulse, digito stays 00, busy stays 0, no done.
- Reset mid-stream: assert reset at cycle 5 → digito=00 and busy=0 from cycle 6; a new start after reset transmits from digit 0.
- Spurious led/start: led_in=1 during cycles 2-4 and start pulsed at cycle 6 → both ignored; timeout result unlocked=0.
- Back-to-back: start held high → second transaction's cycle 1 follows one IDLE cycle after DONE; unlocked clears at the second accept.
